// File: rtl/posit_dot_acc_if.sv
// rtl/posit_dot_acc_if.sv - operand-pair and result handshake bundle for posit_dot_acc
interface posit_dot_acc_if #(
  parameter int WIDTH = 8,
  parameter int EXP   = 2,
  parameter int LEN   = 16
);
  localparam int MTS   = WIDTH - 3 - EXP;
  localparam int REGI  = $clog2(WIDTH) + 1;
  localparam int BIAS  = 2**(EXP+1) * (WIDTH-2);
  localparam int ACC_W = 2*BIAS + 2*MTS + 3 + $clog2(LEN);

  // operand-pair side
  logic                   vld_i;
  logic                   rdy_o;
  logic                   sign_a;
  logic                   sign_b;
  logic signed [REGI-1:0] regi_a;
  logic signed [REGI-1:0] regi_b;
  logic [EXP-1:0]         exp_a;
  logic [EXP-1:0]         exp_b;
  logic [MTS-1:0]         mts_a;
  logic [MTS-1:0]         mts_b;
  logic [1:0]             vld_a;
  logic [1:0]             vld_b;

  // result side
  logic                   out_vld_o;
  logic                   out_rdy_i;
  logic [ACC_W-1:0]       acc_o;
  logic                   nar_o;

  modport master (
    output vld_i, sign_a, sign_b, regi_a, regi_b, exp_a, exp_b,
           mts_a, mts_b, vld_a, vld_b, out_rdy_i,
    input  rdy_o, out_vld_o, acc_o, nar_o
  );

  modport slave (
    input  vld_i, sign_a, sign_b, regi_a, regi_b, exp_a, exp_b,
           mts_a, mts_b, vld_a, vld_b, out_rdy_i,
    output rdy_o, out_vld_o, acc_o, nar_o
  );
endinterface

// File: rtl/posit_dot_acc.sv
// rtl/posit_dot_acc.sv - exact posit dot-product accumulator (quire-style); optional NaR tracking under POSIT_DOT_NAR_EN
module posit_dot_acc #(
  parameter int WIDTH = 8,
  parameter int EXP   = 2,
  parameter int LEN   = 16
) (
  input  logic            clk_i,
  input  logic            rst,
  posit_dot_acc_if.slave  bus
);
  localparam int MTS   = WIDTH - 3 - EXP;
  localparam int REGI  = $clog2(WIDTH) + 1;
  localparam int BIAS  = 2**(EXP+1) * (WIDTH-2);
  localparam int ACC_W = 2*BIAS + 2*MTS + 3 + $clog2(LEN);
  localparam int PW    = 2*MTS + 2;
  localparam int SH_W  = $clog2(2*BIAS + 1);
  localparam int CW    = $clog2(LEN);
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  typedef enum logic [1:0] {IDLE, ACC, DRAIN, HOLD} state_t;

  state_t          state_q, state_d;
  logic            rdy;
  logic            accept;
  logic            clr;
  logic [CW-1:0]   cnt_q;

  logic [PW-1:0]   prod_c;
  logic [SH_W-1:0] shift_c;
  logic [SH_W-1:0] ra_ext, rb_ext;
  logic            skip_c;

  logic            s1_vld;
  logic [PW-1:0]   s1_p;
  logic [SH_W-1:0] s1_shift;
  logic            s1_sign;
  logic            s1_skip;

  logic [ACC_W-1:0] mag;
  logic [ACC_W-1:0] term;
  logic [ACC_W-1:0] acc_q;

  // state register
  always_ff @(posedge clk_i) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next-state, ready and clear-on-first-accept decode
  always_comb begin
    state_d = state_q;
    rdy     = 1'b0;
    clr     = 1'b0;
    case (state_q)
      IDLE: begin
        rdy = 1'b1;
        if (bus.vld_i) begin
          clr     = 1'b1;
          state_d = ACC;
        end
      end
      ACC: begin
        rdy = 1'b1;
        if (bus.vld_i && cnt_q == LAST) state_d = DRAIN;
      end
      DRAIN: state_d = HOLD;
      HOLD:  if (bus.out_rdy_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign accept        = bus.vld_i & rdy;
  assign bus.rdy_o     = rdy;
  assign bus.out_vld_o = (state_q == HOLD);

  // beat counter: first accept loads 1, the LEN-th accept wraps it to 0
  always_ff @(posedge clk_i) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (accept) begin
      if (state_q == IDLE)   cnt_q <= CW'(1);
      else if (cnt_q == LAST) cnt_q <= '0;
      else                   cnt_q <= cnt_q + CW'(1);
    end
  end

  // product, scale and class decode of the presented pair; the shift is
  // computed modulo 2^SH_W, which is exact because legal inputs land in range
  always_comb begin
    prod_c  = PW'({1'b1, bus.mts_a}) * PW'({1'b1, bus.mts_b});
    ra_ext  = {{(SH_W-REGI){bus.regi_a[REGI-1]}}, bus.regi_a};
    rb_ext  = {{(SH_W-REGI){bus.regi_b[REGI-1]}}, bus.regi_b};
    shift_c = ((ra_ext + rb_ext) << EXP) + SH_W'(bus.exp_a) + SH_W'(bus.exp_b)
              + SH_W'(BIAS);
    skip_c  = (bus.vld_a == 2'b00) | (bus.vld_b == 2'b00)
            | (bus.vld_a == 2'b10) | (bus.vld_b == 2'b10);
  end

  // stage 1: capture the decoded product on accept
  always_ff @(posedge clk_i) begin
    if (rst) begin
      s1_vld   <= 1'b0;
      s1_p     <= '0;
      s1_shift <= '0;
      s1_sign  <= 1'b0;
      s1_skip  <= 1'b0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_p     <= prod_c;
        s1_shift <= shift_c;
        s1_sign  <= bus.sign_a ^ bus.sign_b;
        s1_skip  <= skip_c;
      end
    end
  end

  // align the product into quire position and apply its sign
  always_comb begin
    mag  = ACC_W'(s1_p) << s1_shift;
    term = s1_sign ? (~mag + ACC_W'(1)) : mag;
  end

  // stage 2: exact accumulate; a first accept clears, and no term is in flight then
  always_ff @(posedge clk_i) begin
    if (rst || clr)             acc_q <= '0;
    else if (s1_vld && !s1_skip) acc_q <= acc_q + term;
  end

  assign bus.acc_o = acc_q;

`ifdef POSIT_DOT_NAR_EN
  logic s1_nar;
  logic nar_q;

  // remember which stage-1 products came from a NaR operand
  always_ff @(posedge clk_i) begin
    if (rst)         s1_nar <= 1'b0;
    else if (accept) s1_nar <= (bus.vld_a == 2'b10) | (bus.vld_b == 2'b10);
  end

  // sticky NaR flag, cleared with the accumulator on the first accept
  always_ff @(posedge clk_i) begin
    if (rst || clr)  nar_q <= 1'b0;
    else if (s1_vld) nar_q <= nar_q | s1_nar;
  end

  assign bus.nar_o = nar_q;
`else
  assign bus.nar_o = 1'b0;
`endif
endmodule

// File: tb/tb_posit_dot_acc.sv
// tb/tb_posit_dot_acc.sv - directed self-checking bench for posit_dot_acc
module tb_posit_dot_acc;
  localparam int WIDTH = 8;
  localparam int EXP   = 2;
  localparam int LEN   = 16;
  localparam int ACC_W = 109;

  typedef logic [ACC_W-1:0] acc_t;

  logic clk_i = 1'b0;
  logic rst   = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic              a_sign [LEN];
  logic              b_sign [LEN];
  logic signed [3:0] a_regi [LEN];
  logic signed [3:0] b_regi [LEN];
  logic [1:0]        a_exp  [LEN];
  logic [1:0]        b_exp  [LEN];
  logic [2:0]        a_mts  [LEN];
  logic [2:0]        b_mts  [LEN];
  logic [1:0]        a_vld  [LEN];
  logic [1:0]        b_vld  [LEN];

  posit_dot_acc_if #(.WIDTH(WIDTH), .EXP(EXP), .LEN(LEN)) bus ();

  posit_dot_acc #(.WIDTH(WIDTH), .EXP(EXP), .LEN(LEN)) dut (
    .clk_i (clk_i),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  function automatic acc_t pow2(input int k);
    acc_t r;
    r = 1;
    return r << k;
  endfunction

  task automatic idle_bus();
    bus.vld_i  = 1'b0;
    bus.sign_a = 1'b0; bus.sign_b = 1'b0;
    bus.regi_a = '0;   bus.regi_b = '0;
    bus.exp_a  = '0;   bus.exp_b  = '0;
    bus.mts_a  = '0;   bus.mts_b  = '0;
    bus.vld_a  = 2'b00; bus.vld_b = 2'b00;
  endtask

  task automatic fill_unity();
    for (int i = 0; i < LEN; i++) begin
      a_sign[i] = 1'b0; b_sign[i] = 1'b0;
      a_regi[i] = '0;   b_regi[i] = '0;
      a_exp[i]  = '0;   b_exp[i]  = '0;
      a_mts[i]  = '0;   b_mts[i]  = '0;
      a_vld[i]  = 2'b01; b_vld[i] = 2'b01;
    end
  endtask

  task automatic drive_beat(input int i);
    bus.sign_a = a_sign[i]; bus.sign_b = b_sign[i];
    bus.regi_a = a_regi[i]; bus.regi_b = b_regi[i];
    bus.exp_a  = a_exp[i];  bus.exp_b  = b_exp[i];
    bus.mts_a  = a_mts[i];  bus.mts_b  = b_mts[i];
    bus.vld_a  = a_vld[i];  bus.vld_b  = b_vld[i];
    bus.vld_i  = 1'b1;
  endtask

  // present beat i and hold it until the edge that accepts it
  task automatic send_beat(input int i, input string name);
    int w;
    drive_beat(i);
    w = 0;
    while (!bus.rdy_o && w < 50) begin
      @(posedge clk_i); #1;
      w++;
    end
    if (w >= 50) begin
      n_checks++; n_fail++;
      $display("FAIL %s_accept_timeout: beat %0d rdy_o=%0b, required 1 within 50 cycles", name, i, bus.rdy_o);
    end else begin
      @(posedge clk_i); #1;
    end
  endtask

  // push LEN beats with out_rdy_i high and check latency and result
  task automatic run_dot(input string name, input acc_t exp_acc, input logic exp_nar, input bit chk_acc);
    for (int i = 0; i < LEN; i++) send_beat(i, name);
    bus.vld_i = 1'b0;
    n_checks++;
    if (bus.out_vld_o !== 1'b0) begin
      n_fail++; $display("FAIL %s_drain_vld: got %0b required 0", name, bus.out_vld_o);
    end
    @(posedge clk_i); #1;
    n_checks++;
    if (bus.out_vld_o !== 1'b1) begin
      n_fail++; $display("FAIL %s_out_vld: got %0b required 1", name, bus.out_vld_o);
    end
    if (chk_acc) begin
      n_checks++;
      if (bus.acc_o !== exp_acc) begin
        n_fail++; $display("FAIL %s_acc: got %0h required %0h", name, bus.acc_o, exp_acc);
      end
    end
    n_checks++;
    if (bus.nar_o !== exp_nar) begin
      n_fail++; $display("FAIL %s_nar: got %0b required %0b", name, bus.nar_o, exp_nar);
    end
    @(posedge clk_i); #1;
    n_checks++;
    if (bus.out_vld_o !== 1'b0) begin
      n_fail++; $display("FAIL %s_release: out_vld_o got %0b required 0", name, bus.out_vld_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_bus();
    bus.out_rdy_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    n_checks++;
    if (bus.out_vld_o !== 1'b0) begin n_fail++; $display("FAIL reset_out_vld: got %0b required 0", bus.out_vld_o); end
    n_checks++;
    if (bus.acc_o !== '0) begin n_fail++; $display("FAIL reset_acc: got %0h required 0", bus.acc_o); end
    n_checks++;
    if (bus.nar_o !== 1'b0) begin n_fail++; $display("FAIL reset_nar: got %0b required 0", bus.nar_o); end
    rst = 1'b0;
    @(posedge clk_i); #1;
    n_checks++;
    if (bus.rdy_o !== 1'b1) begin n_fail++; $display("FAIL reset_rdy: got %0b required 1", bus.rdy_o); end
  endtask

  task automatic test_unity();
    fill_unity();
    run_dot("unity", pow2(58), 1'b0, 1'b1);
  endtask

  task automatic test_cancel();
    fill_unity();
    for (int i = 1; i < LEN; i += 2) b_sign[i] = 1'b1;
    run_dot("cancel", '0, 1'b0, 1'b1);
    fill_unity();
    for (int i = 0; i < LEN; i++) begin
      a_regi[i] = -4'sd6;
      b_regi[i] = -4'sd6;
    end
    run_dot("minpos", acc_t'(1024), 1'b0, 1'b1);
  endtask

  task automatic test_zero_skip();
    fill_unity();
    for (int i = 0; i < 8; i++) b_vld[i] = 2'b00;
    for (int i = 8; i < LEN; i++) b_exp[i] = 2'd1;
    run_dot("zero_skip", pow2(58), 1'b0, 1'b1);
  endtask

  task automatic test_nar();
    fill_unity();
    a_vld[3] = 2'b10;
`ifdef POSIT_DOT_NAR_EN
    run_dot("nar", '0, 1'b1, 1'b0);
`else
    run_dot("nar", pow2(58) - pow2(54), 1'b0, 1'b1);
`endif
  endtask

  task automatic test_hold();
    fill_unity();
    bus.out_rdy_i = 1'b0;
    for (int i = 0; i < LEN; i++) send_beat(i, "hold_fill");
    bus.vld_i = 1'b0;
    @(posedge clk_i); #1;
    for (int i = 0; i < LEN; i++) b_exp[i] = 2'd1;
    drive_beat(0);
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (bus.out_vld_o !== 1'b1) begin n_fail++; $display("FAIL hold_vld[%0d]: got %0b required 1", k, bus.out_vld_o); end
      n_checks++;
      if (bus.acc_o !== pow2(58)) begin n_fail++; $display("FAIL hold_acc[%0d]: got %0h required %0h", k, bus.acc_o, pow2(58)); end
      n_checks++;
      if (bus.nar_o !== 1'b0) begin n_fail++; $display("FAIL hold_nar[%0d]: got %0b required 0", k, bus.nar_o); end
      n_checks++;
      if (bus.rdy_o !== 1'b0) begin n_fail++; $display("FAIL hold_rdy[%0d]: got %0b required 0", k, bus.rdy_o); end
      @(posedge clk_i); #1;
    end
    bus.out_rdy_i = 1'b1;
    run_dot("after_hold", pow2(59), 1'b0, 1'b1);
  endtask

  task automatic test_mid_reset();
    fill_unity();
    for (int i = 0; i < 7; i++) send_beat(i, "mid_reset");
    bus.vld_i = 1'b0;
    @(posedge clk_i); #1;
    rst = 1'b1;
    @(posedge clk_i); #1;
    n_checks++;
    if (bus.acc_o !== '0) begin n_fail++; $display("FAIL mid_reset_acc: got %0h required 0", bus.acc_o); end
    n_checks++;
    if (bus.out_vld_o !== 1'b0) begin n_fail++; $display("FAIL mid_reset_vld: got %0b required 0", bus.out_vld_o); end
    n_checks++;
    if (bus.nar_o !== 1'b0) begin n_fail++; $display("FAIL mid_reset_nar: got %0b required 0", bus.nar_o); end
    rst = 1'b0;
    @(posedge clk_i); #1;
    n_checks++;
    if (bus.rdy_o !== 1'b1) begin n_fail++; $display("FAIL mid_reset_rdy: got %0b required 1", bus.rdy_o); end
    run_dot("post_reset", pow2(58), 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_unity();
    test_cancel();
    test_zero_skip();
    test_nar();
    test_hold();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/posit_dot_acc.md
Name: posit_dot_acc

Overview:
- Downstream stage of the dual-operand posit decoder.
- Each beat, consumes one decoded operand pair (sign, regime, exponent, mantissa, validity code), forms the exact product, and adds it into a wide signed fixed-point accumulator (quire-style).
- After LEN pairs, presents the exact dot-product sum to the rounding/encode stage through a valid/ready handshake.

Parameters:
- WIDTH, 8, posit bitwidth of the decoded operands.
- EXP, 2, exponent field bits.
- LEN, 16, operand pairs per dot product (power of two, ≥2).
- Localparam MTS = WIDTH-3-EXP, mantissa bits.
- Localparam REGI = $clog2(WIDTH)+1, signed regime width.
- Localparam BIAS = 2**(EXP+1)*(WIDTH-2), shift offset.
- Localparam ACC_W = 2*BIAS + 2*MTS + 3 + $clog2(LEN), accumulator width.

Ports:
- clk_i  in  1  clock.
- rst  in  1  synchronous active-high reset.
- vld_i  in  1  operand pair valid.
- rdy_o  out  1  block can accept a pair.
- sign_a, sign_b  in  1 each  operand signs.
- regi_a, regi_b  in  REGI each  signed regime values.
- exp_a, exp_b  in  EXP each  exponent fields.
- mts_a, mts_b  in  MTS each  mantissa fractions (hidden bit implicit).
- vld_a, vld_b  in  2 each  class codes: 00 zero, 01 normal, 10 NaR.
- out_vld_o  out  1  result valid.
- out_rdy_i  in  1  downstream accepts result.
- acc_o  out  ACC_W  signed sum; LSB weight 2^-(BIAS+2*MTS).
- nar_o  out  1  result is NaR.

Behaviour:
- Reset: one clock and synchronous active-high reset `rst` on `clk_i`.
  - On reset: state=IDLE, acc_o=0, nar_o=0, out_vld_o=0, beat counter=0, pipeline valid=0. rdy_o=1 the cycle after reset deasserts.
- Accept rule: a pair is accepted when vld_i & rdy_o. rdy_o=1 in IDLE and ACC, 0 in DRAIN and HOLD. Upstream must hold or stall pairs while rdy_o=0; pairs presented while rdy_o=0 are ignored.
- Stage 1 (registered on accept):
  - P = {1,mts_a} * {1,mts_b}, unsigned, 2*MTS+2 bits.
  - shift = (regi_a+regi_b)*2^EXP + exp_a + exp_b + BIAS; always in [0, 2*BIAS] for legal decoder output.
  - psign = sign_a ^ sign_b.
  - pzero = (vld_a==00)|(vld_b==00).
  - pnar = (vld_a==10)|(vld_b==10).
- Stage 2 (cycle after stage 1 valid):
  - term = P << shift, sign-extended to ACC_W, negated if psign.
  - acc += term unless pzero or pnar; nar sticky-ORs pnar.
  - Exact; no overflow possible by ACC_W sizing.
- FSM:
  - IDLE: on accept, clear acc and nar in the same cycle (first term adds onto 0), counter=1, go to ACC.
  - ACC: each accept increments counter; the accept that makes counter==LEN goes to DRAIN, counter→0.
  - DRAIN: one cycle for stage 2 to absorb the last product; go to HOLD with out_vld_o=1.
  - HOLD: acc_o, nar_o, out_vld_o stable until out_rdy_i=1, then go to IDLE with out_vld_o=0 next cycle.
- Latency: last pair accepted at cycle t → out_vld_o=1 at t+2 if out_rdy_i is already high. Minimum initiation interval per dot product is LEN+2 cycles.
- acc_o/nar_o hold their last value in IDLE until the next first accept clears them.
- Gaps (vld_i=0) inside ACC are allowed; the counter holds.
- rst asserted mid-dot-product or in HOLD discards everything and returns to reset values on the next edge.

Optional Feature:
- POSIT_DOT_NAR_EN defined: NaR handling as above; NaR in either operand sets sticky nar_o. acc_o continues to accumulate non-NaR terms and is don't-care when nar_o=1.
- Undefined: pnar logic removed. NaR operands are treated as zero (term skipped). nar_o is tied to 0.

Test Plan:
- 16 pairs of 1.0×1.0 (regi=0, exp=0, mts=0, vld=01) → one result, acc_o = 16·2^54 = 2^58, nar_o=0, out_vld_o at cycle t+2 after the 16th accept.
- Alternating 1.0×1.0 and 1.0×(-1.0) (sign_b=1), 16 pairs → acc_o=0. Then 16 pairs of minpos×minpos (regi=-6, exp=0, mts=0) → acc_o = 16·64 = 1024, first term not polluted by the previous result.
- Pairs with vld_b=00 on beats 0–7 and 1.0×2.0 (exp_b=1) on beats 8–15 → acc_o = 8·2^55 = 2^58.
- vld_a=10 on beat 3, rest 1.0×1.0:
  - with POSIT_DOT_NAR_EN → nar_o=1;
  - without → nar_o=0, acc_o = 15·2^54.
- out_rdy_i held low 5 cycles in HOLD while vld_i=1 → out_vld_o, acc_o, nar_o stable and rdy_o=0 throughout. The next dot product starts only after out_rdy_i=1, and no pairs are lost when upstream holds.
- rst asserted after 7 of 16 pairs → all outputs 0 the next cycle. A following full 16-pair run of 1.0×1.0 → acc_o = 2^58.
